pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter NSTAGE, default 5, number of pipeline stages; stage 0 = PC/fetch, index rises toward writeback.
REQ-002 Parameter MC_STAGE, default 3, stage index stalled by the multi-cycle unit; range 0..NSTAGE-1.
REQ-003 Parameter MCW, default 6, width of the multi-cycle length field.
REQ-004 Parameter PCW, default 32, width of the redirect PC.
REQ-005 Parameter CNTW, default 32, width of the stall-cycle counter.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 stallreq  in  NSTAGE  bit k = stage k requests a stall this cycle.
REQ-009 mc_start  in  1  one-cycle pulse; a multi-cycle operation starts in MC_STAGE.
REQ-010 mc_len  in  MCW  total stall cycles for the operation; sampled with mc_start.
REQ-011 flush_req  in  1  exception/flush request; sampled each cycle.
REQ-012 flush_pc  in  PCW  handler PC; sampled with flush_req.
REQ-013 redir_ready  in  1  fetch accepts the redirect PC.
REQ-014 stall  out  NSTAGE  bit i = hold stage i register.
REQ-015 flush  out  1  clear all stage registers this cycle.
REQ-016 redir_valid  out  1  redirect PC offered to fetch.
REQ-017 redir_pc  out  PCW  redirect target.
REQ-018 busy  out  1  FSM not in IDLE.
REQ-019 stall_cnt  out  CNTW  count of cycles with stall[0]=1.

Function
REQ-020 FSM states: IDLE, MC_BUSY, FLUSH, REDIRECT; encoded in 2 bits.
REQ-021 Effective request eff[k] = stallreq[k] OR (k==MC_STAGE AND mc_active); mc_active = (IDLE AND mc_start AND mc_len!=0) OR MC_BUSY.
REQ-022 In IDLE/MC_BUSY, stall is combinational: h = highest k with eff[k]=1; stall[i]=1 for all i<=h, 0 above; all zeros if no eff bit set.
REQ-023 Bubble into stage h+1 is implied by stall[h]=1, stall[h+1]=0; no separate output.
REQ-024 IDLE, mc_start=1, mc_len=L>=2, flush_req=0: MC_BUSY next cycle with counter=L-1; MC_STAGE stall asserted exactly L consecutive cycles starting at the mc_start cycle.
REQ-025 mc_len=1: stall for the start cycle only, remain IDLE; mc_len=0: mc_start ignored.
REQ-026 MC_BUSY: counter decrements each cycle; counter==1 returns to IDLE next cycle; mc_start while MC_BUSY ignored.
REQ-027 flush_req=1 in IDLE or MC_BUSY: capture flush_pc into redir_pc, next state FLUSH, abort MC countdown; stall on that cycle per REQ-022.
REQ-028 FLUSH lasts exactly one cycle: flush=1, stall all zeros; next state REDIRECT.
REQ-029 REDIRECT: redir_valid=1, redir_pc held stable, stall[0]=1, other bits 0; redir_ready=1 returns to IDLE next cycle, redir_valid low then.
REQ-030 flush_req in FLUSH or REDIRECT ignored; first flush wins, redir_pc unchanged.
REQ-031 flush_req and mc_start same cycle in IDLE: flush wins; MC not started.
REQ-032 stall_cnt increments by 1 each cycle stall[0]=1; saturates at all-ones, no wrap.
REQ-033 busy = (state != IDLE), registered-state derived.

Reset
REQ-034 rst_n low at a clock edge: state IDLE, MC counter 0, redir_pc 0, stall_cnt 0.
REQ-035 While rst_n=0, stall, flush, redir_valid forced 0 combinationally.
REQ-036 Reset mid-MC_BUSY or mid-REDIRECT abandons operation; no residual stall after release.

Structure
REQ-037 Shared package pipe_ctrl_pkg holds state enum and default parameter constants.
REQ-038 Sub-module pipe_ctrl_mctimer: loadable MCW-bit down-counter with load/abort/done.
REQ-039 Stall priority encoder generic over NSTAGE, no hard-coded vectors.

Verification
REQ-040 NSTAGE=5: stallreq=5'b00100 -> stall=5'b00111; stallreq=5'b01010 -> stall=5'b01111; 0 -> 0.
REQ-041 mc_start, mc_len=4, MC_STAGE=3 -> stall=5'b01111 for exactly 4 cycles, busy high 3 cycles, then 0.
REQ-042 MC_BUSY cycle 2, flush_req, flush_pc=0xBFC00380 -> next cycle flush=1, stall=0; then redir_valid=1, redir_pc=0xBFC00380, stall=5'b00001 until redir_ready.
REQ-043 Second flush_req (0x80000000) during REDIRECT -> redir_pc stays 0xBFC00380; redir_ready held low 3 cycles -> stall_cnt +3.
REQ-044 rst_n low one cycle mid-MC_BUSY (len 10) -> stall=0 during reset, IDLE after, stall_cnt=0.
REQ-045 Force stall_cnt near all-ones (CNTW=4), 20 stall cycles -> stall_cnt holds 4'hF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default parameter values for the pipeline controller.
package pipe_ctrl_pkg;

   // Controller FSM states, 2-bit encoding
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MC_BUSY  = 2'd1,
      ST_FLUSH    = 2'd2,
      ST_REDIRECT = 2'd3
   } state_e;

   localparam int DEF_NSTAGE   = 5;
   localparam int DEF_MC_STAGE = 3;
   localparam int DEF_MCW      = 6;
   localparam int DEF_PCW      = 32;
   localparam int DEF_CNTW     = 32;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of pipeline request inputs and controller outputs.
// master = pipeline side driving requests, slave = pipe_ctrl.
interface pipe_ctrl_if
   import pipe_ctrl_pkg::*;
#(
   parameter int NSTAGE = DEF_NSTAGE,
   parameter int MCW    = DEF_MCW,
   parameter int PCW    = DEF_PCW,
   parameter int CNTW   = DEF_CNTW
);
   logic [NSTAGE-1:0] stallreq;
   logic              mc_start;
   logic [MCW-1:0]    mc_len;
   logic              flush_req;
   logic [PCW-1:0]    flush_pc;
   logic              redir_ready;
   logic [NSTAGE-1:0] stall;
   logic              flush;
   logic              redir_valid;
   logic [PCW-1:0]    redir_pc;
   logic              busy;
   logic [CNTW-1:0]   stall_cnt;

   modport master (
      output stallreq, mc_start, mc_len, flush_req, flush_pc, redir_ready,
      input  stall, flush, redir_valid, redir_pc, busy, stall_cnt
   );

   modport slave (
      input  stallreq, mc_start, mc_len, flush_req, flush_pc, redir_ready,
      output stall, flush, redir_valid, redir_pc, busy, stall_cnt
   );
endinterface

// File: rtl/pipe_ctrl_mctimer.sv
// Loadable down-counter timing a multi-cycle operation.
// done flags the final counted cycle (counter == 1).
module pipe_ctrl_mctimer
   import pipe_ctrl_pkg::*;
#(
   parameter int MCW = DEF_MCW
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic [MCW-1:0] load_val,
   input  logic           abort,
   output logic           done
);
   logic [MCW-1:0] cnt_q, cnt_d;

   // Load has priority over abort; otherwise count down to zero and stop
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (abort) begin
         cnt_d = '0;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - MCW'(1);
      end
   end

   // Counter register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == MCW'(1));
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: stall priority encoding, multi-cycle
// unit hold-off, flush + redirect sequencing and a saturating stall counter.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int NSTAGE   = DEF_NSTAGE,
   parameter int MC_STAGE = DEF_MC_STAGE,
   parameter int MCW      = DEF_MCW,
   parameter int PCW      = DEF_PCW,
   parameter int CNTW     = DEF_CNTW
) (
   input  logic       clk,
   input  logic       rst_n,
   pipe_ctrl_if.slave bus
);
   state_e            state_q, state_d;
   logic [PCW-1:0]    redir_pc_q, redir_pc_d;
   logic [CNTW-1:0]   stall_cnt_q, stall_cnt_d;

   logic              mc_active;
   logic              mc_load;
   logic              mc_abort;
   logic [MCW-1:0]    mc_load_val;
   logic              mc_done;

   logic [NSTAGE-1:0] eff;
   logic [NSTAGE-1:0] pe_stall;
   logic [NSTAGE-1:0] stall_o;
   logic              flush_o;
   logic              redir_valid_o;

   // The start cycle itself already holds MC_STAGE, before MC_BUSY is entered
   assign mc_active = ((state_q == ST_IDLE) && bus.mc_start && (bus.mc_len != '0))
                      || (state_q == ST_MC_BUSY);

   // Effective requests and "hold everything at or below the highest request"
   genvar gi;
   generate
      for (gi = 0; gi < NSTAGE; gi++) begin : g_stall_pe
         assign eff[gi]      = bus.stallreq[gi] | ((gi == MC_STAGE) & mc_active);
         assign pe_stall[gi] = |eff[NSTAGE-1:gi];
      end
   endgenerate

   pipe_ctrl_mctimer #(
      .MCW (MCW)
   ) u_mctimer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (mc_load),
      .load_val (mc_load_val),
      .abort    (mc_abort),
      .done     (mc_done)
   );

   // Next-state logic: flush beats a multi-cycle start; later flushes are ignored
   always_comb begin
      state_d     = state_q;
      redir_pc_d  = redir_pc_q;
      mc_load     = 1'b0;
      mc_abort    = 1'b0;
      mc_load_val = bus.mc_len - MCW'(1);
      case (state_q)
         ST_IDLE: begin
            if (bus.flush_req) begin
               state_d    = ST_FLUSH;
               redir_pc_d = bus.flush_pc;
               mc_abort   = 1'b1;
            end else if (bus.mc_start && (bus.mc_len > MCW'(1))) begin
               state_d = ST_MC_BUSY;
               mc_load = 1'b1;
            end
         end
         ST_MC_BUSY: begin
            if (bus.flush_req) begin
               state_d    = ST_FLUSH;
               redir_pc_d = bus.flush_pc;
               mc_abort   = 1'b1;
            end else if (mc_done) begin
               state_d = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            state_d = ST_REDIRECT;
         end
         ST_REDIRECT: begin
            if (bus.redir_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs per state; held inactive while reset is asserted
   always_comb begin
      stall_o       = '0;
      flush_o       = 1'b0;
      redir_valid_o = 1'b0;
      if (rst_n) begin
         case (state_q)
            ST_IDLE, ST_MC_BUSY: begin
               stall_o = pe_stall;
            end
            ST_FLUSH: begin
               flush_o = 1'b1;
            end
            ST_REDIRECT: begin
               redir_valid_o = 1'b1;
               stall_o[0]    = 1'b1;
            end
            default: begin
               stall_o = '0;
            end
         endcase
      end
   end

   // Saturating count of cycles in which fetch is held
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_o[0] && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNTW'(1);
      end
   end

   // State, redirect target and counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         redir_pc_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         redir_pc_q  <= redir_pc_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.stall       = stall_o;
   assign bus.flush       = flush_o;
   assign bus.redir_valid = redir_valid_o;
   assign bus.redir_pc    = redir_pc_q;
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: encoder vectors, multi-cycle holds,
// flush/redirect sequence, reset abandonment and counter saturation.
module tb_pipe_ctrl;
   logic clk;
   logic rst_n;
   logic rst1_n;

   int total  = 0;
   int passed = 0;
   int fails  = 0;
   int exp_cnt = 0;

   pipe_ctrl_if #(.NSTAGE(5), .MCW(6), .PCW(32), .CNTW(32)) if0 ();
   pipe_ctrl_if #(.NSTAGE(5), .MCW(6), .PCW(32), .CNTW(4))  if1 ();

   pipe_ctrl #(.NSTAGE(5), .MC_STAGE(3), .MCW(6), .PCW(32), .CNTW(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if0.slave)
   );

   pipe_ctrl #(.NSTAGE(5), .MC_STAGE(3), .MCW(6), .PCW(32), .CNTW(4)) dut_sat (
      .clk   (clk),
      .rst_n (rst1_n),
      .bus   (if1.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check outputs mid-cycle, then advance one clock; exp_cnt follows stall[0]
   task automatic step(input string tag, input logic [4:0] e_stall, input logic e_flush,
                       input logic e_rv, input logic e_busy, input logic chk_stall);
      #4;
      if (chk_stall) chk({tag, ".stall"}, 64'(if0.stall), 64'(e_stall));
      chk({tag, ".flush"}, 64'(if0.flush), 64'(e_flush));
      chk({tag, ".redir_valid"}, 64'(if0.redir_valid), 64'(e_rv));
      chk({tag, ".busy"}, 64'(if0.busy), 64'(e_busy));
      chk({tag, ".stall_cnt"}, 64'(if0.stall_cnt), 64'(exp_cnt));
      $display("step %s stall=%b flush=%b rv=%b busy=%b cnt=%0d pc=%h",
               tag, if0.stall, if0.flush, if0.redir_valid, if0.busy, if0.stall_cnt, if0.redir_pc);
      @(posedge clk);
      #1;
      if (!rst_n) exp_cnt = 0;
      else if (e_stall[0]) exp_cnt++;
   endtask

   initial begin
      rst_n  = 1'b0;
      rst1_n = 1'b0;
      if0.stallreq = 5'b11111; if0.mc_start = 1'b0; if0.mc_len = '0;
      if0.flush_req = 1'b0; if0.flush_pc = '0; if0.redir_ready = 1'b0;
      if1.stallreq = 5'b00000; if1.mc_start = 1'b0; if1.mc_len = '0;
      if1.flush_req = 1'b0; if1.flush_pc = '0; if1.redir_ready = 1'b0;

      // Reset: outputs forced low even with requests present
      step("rst0", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);
      step("rst1", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);
      rst_n = 1'b1;
      if0.stallreq = 5'b00000;
      #4;
      chk("rst.redir_pc", 64'(if0.redir_pc), 64'h0);
      chk("rst.stall_cnt", 64'(if0.stall_cnt), 64'd0);
      #1; @(posedge clk); #1;

      // Priority encoder vectors
      if0.stallreq = 5'b00100; step("pe_00100", 5'b00111, 1'b0, 1'b0, 1'b0, 1'b1);
      if0.stallreq = 5'b01010; step("pe_01010", 5'b01111, 1'b0, 1'b0, 1'b0, 1'b1);
      if0.stallreq = 5'b00000; step("pe_00000", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);
      if0.stallreq = 5'b10000; step("pe_10000", 5'b11111, 1'b0, 1'b0, 1'b0, 1'b1);
      if0.stallreq = 5'b00001; step("pe_00001", 5'b00001, 1'b0, 1'b0, 1'b0, 1'b1);
      if0.stallreq = 5'b00000;

      // Multi-cycle length 4: four held cycles, busy for the last three
      if0.mc_start = 1'b1; if0.mc_len = 6'd4;
      step("mc4_c0", 5'b01111, 1'b0, 1'b0, 1'b0, 1'b1);
      if0.mc_start = 1'b0; if0.mc_len = 6'd0;
      step("mc4_c1", 5'b01111, 1'b0, 1'b0, 1'b1, 1'b1);
      step("mc4_c2", 5'b01111, 1'b0, 1'b0, 1'b1, 1'b1);
      step("mc4_c3", 5'b01111, 1'b0, 1'b0, 1'b1, 1'b1);
      step("mc4_end", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);

      // Length 1: single held cycle, no busy; length 0: ignored
      if0.mc_start = 1'b1; if0.mc_len = 6'd1;
      step("mc1_c0", 5'b01111, 1'b0, 1'b0, 1'b0, 1'b1);
      if0.mc_start = 1'b0;
      step("mc1_end", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);
      if0.mc_start = 1'b1; if0.mc_len = 6'd0;
      step("mc0_c0", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);
      if0.mc_start = 1'b0;
      step("mc0_end", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);

      // Flush during MC_BUSY cycle 2, then redirect with an ignored second flush
      if0.mc_start = 1'b1; if0.mc_len = 6'd6;
      step("fl_start", 5'b01111, 1'b0, 1'b0, 1'b0, 1'b1);
      if0.mc_start = 1'b0; if0.mc_len = 6'd0;
      step("fl_busy1", 5'b01111, 1'b0, 1'b0, 1'b1, 1'b1);
      if0.flush_req = 1'b1; if0.flush_pc = 32'hBFC00380;
      step("fl_busy2", 5'b01111, 1'b0, 1'b0, 1'b1, 1'b1);
      if0.flush_req = 1'b0; if0.flush_pc = '0;
      step("fl_flush", 5'b00000, 1'b1, 1'b0, 1'b1, 1'b1);
      if0.flush_req = 1'b1; if0.flush_pc = 32'h80000000;
      chk("rd0.redir_pc", 64'(if0.redir_pc), 64'hBFC00380);
      step("rd0", 5'b00001, 1'b0, 1'b1, 1'b1, 1'b1);
      if0.flush_req = 1'b0; if0.flush_pc = '0;
      chk("rd1.redir_pc", 64'(if0.redir_pc), 64'hBFC00380);
      step("rd1", 5'b00001, 1'b0, 1'b1, 1'b1, 1'b1);
      step("rd2", 5'b00001, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("rd.stall_cnt_plus3", 64'(if0.stall_cnt), 64'd15);
      if0.redir_ready = 1'b1;
      step("rd3_ready", 5'b00001, 1'b0, 1'b1, 1'b1, 1'b1);
      if0.redir_ready = 1'b0;
      chk("rd_done.redir_pc", 64'(if0.redir_pc), 64'hBFC00380);
      step("rd_done", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);

      // Flush and mc_start together in IDLE: flush wins, MC never runs
      if0.stallreq = 5'b00001; if0.flush_req = 1'b1; if0.flush_pc = 32'h00001234;
      if0.mc_start = 1'b1; if0.mc_len = 6'd5;
      step("fm_req", 5'b00001, 1'b0, 1'b0, 1'b0, 1'b0);
      if0.stallreq = 5'b00000; if0.flush_req = 1'b0; if0.flush_pc = '0;
      if0.mc_start = 1'b0; if0.mc_len = 6'd0;
      step("fm_flush", 5'b00000, 1'b1, 1'b0, 1'b1, 1'b1);
      if0.redir_ready = 1'b1;
      chk("fm.redir_pc", 64'(if0.redir_pc), 64'h00001234);
      step("fm_redir", 5'b00001, 1'b0, 1'b1, 1'b1, 1'b1);
      if0.redir_ready = 1'b0;
      step("fm_idle", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);
      step("fm_idle2", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);

      // Reset mid-MC_BUSY (length 10) abandons the operation
      if0.mc_start = 1'b1; if0.mc_len = 6'd10;
      step("mr_start", 5'b01111, 1'b0, 1'b0, 1'b0, 1'b1);
      if0.mc_start = 1'b0; if0.mc_len = 6'd0;
      step("mr_busy1", 5'b01111, 1'b0, 1'b0, 1'b1, 1'b1);
      step("mr_busy2", 5'b01111, 1'b0, 1'b0, 1'b1, 1'b1);
      rst_n = 1'b0;
      step("mr_rst", 5'b00000, 1'b0, 1'b0, 1'b1, 1'b1);
      rst_n = 1'b1;
      step("mr_after", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);
      step("mr_after2", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);

      // 4-bit counter saturates at 4'hF over 20 held cycles
      rst1_n = 1'b1;
      if1.stallreq = 5'b00001;
      for (int i = 0; i <= 20; i++) begin
         #4;
         chk($sformatf("sat_%0d", i), 64'(if1.stall_cnt), (i < 15) ? 64'(i) : 64'd15);
         $display("sat cycle %0d stall_cnt=%0h", i, if1.stall_cnt);
         @(posedge clk);
         #1;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
